atb_update_ctrl: RTL and testbench
==================================

// Module: atb_update_ctrl
// PURPOSE
//   Update/maintenance controller in front of the ATB write side. Accepts up to two
//   retire updates per cycle into a small ordered queue and serializes them onto the
//   ATB's single write port, one per cycle. Also sequences a full-table flush by
//   walking every ATB index on an invalidate port. Sits between retire and the ATB.
// PARAMETERS
//   N      256  ATB entries; power of 2; index = pc[IDX_W-1:0] (pc % N)
//   DEPTH  4    update queue entries; power of 2, >= 2
//   IDX_W  $clog2(N)  derived, not overridden
// PORTS
//   clk              in   1      clock, all state on posedge
//   reset_n          in   1      async active-low reset
//   ret0_valid_i     in   1      retire lane 0 update valid (older)
//   ret0_pc_i        in   32     lane 0 branch PC
//   ret0_tgt_pc_i    in   32     lane 0 target PC
//   ret1_valid_i     in   1      retire lane 1 update valid (younger)
//   ret1_pc_i        in   32     lane 1 branch PC
//   ret1_tgt_pc_i    in   32     lane 1 target PC
//   ret_ready_o      out  1      both lanes may push this cycle
//   flush_req_i      in   1      request full ATB invalidate (sampled in IDLE only)
//   flush_busy_o     out  1      flush in progress; ATB lookups must be gated off
//   flush_done_o     out  1      one-cycle pulse, flush complete
//   atb_wr_valid_o   out  1      ATB write strobe (ATB retire_valid_i)
//   atb_wr_pc_o      out  32     ATB write PC
//   atb_wr_tgt_pc_o  out  32     ATB write target
//   atb_inv_valid_o  out  1      ATB invalidate strobe (clears one valid bit)
//   atb_inv_idx_o    out  IDX_W  index to invalidate
//   q_count_o        out  $clog2(DEPTH+1)  queue occupancy
// BEHAVIOUR
//   - Reset: FSM=IDLE, queue empty, flush counter 0. Outputs: ret_ready_o=1, all
//     other outputs 0. Reset mid-flush aborts the walk; ATB valid bits are cleared by
//     the ATB's own reset.
//   - FSM: IDLE -> FLUSH (flush_req_i=1) ; FLUSH -> DONE (idx==N-1) ; DONE -> IDLE.
//   - ret_ready_o = (state==IDLE) && (DEPTH - q_count >= 2), evaluated with the pop of
//     the current cycle NOT credited. Push only when valid && ready; a valid without
//     ready is lost (retire must hold-off). Lane0 enqueued before lane1 same cycle.
//   - Write port: atb_wr_* = queue head whenever state==IDLE && q_count>0; head pops
//     that cycle (ATB never back-pressures). Push at edge t -> write visible cycle t+1
//     at earliest. Push and pop in same cycle are legal; count updates net.
//   - Flush accepted in IDLE cycle t: queue cleared at edge t+1, including any
//     updates accepted in cycle t (flush voids all older and same-cycle updates);
//     no atb_wr_valid_o in cycle t either. Cycles t+1..t+N: atb_inv_valid_o=1,
//     atb_inv_idx_o=0..N-1, counter wraps to 0. Cycle t+N+1: DONE, flush_done_o=1.
//   - flush_busy_o = (state!=IDLE). flush_req_i ignored outside IDLE.
//   - atb_wr_valid_o and atb_inv_valid_o never high in the same cycle.
//   - Queue pointers IDX wrap modulo DEPTH; count saturates impossible by ready rule.
// CONFIGURATION
//   ATB_UPD_COALESCE_EN defined: an incoming update whose pc equals a queued entry
//     that is not popping this cycle overwrites that entry's target in place (no new
//     push); same-PC lane0/lane1 pair in one cycle -> single entry with lane1 target.
//   Not defined: every accepted update is pushed; duplicates written in order.
// STRUCTURE
//   atb_pkg: atb_upd_t {pc[31:0], tgt_pc[31:0]}; atb_ctrl_state_e {IDLE,FLUSH,DONE}.
//   Sub-module atb_upd_fifo: 2-push/1-pop/clear FIFO of atb_upd_t, DEPTH param,
//     exports count; coalesce compare lives in the FIFO under the macro.
//   Top: FSM, flush index counter, output muxing.
// TESTING
//   1 lane0 pc=0x100 tgt=0x200 cyc0 -> cyc1 atb_wr_valid=1 pc=0x100 tgt=0x200; cyc2 0.
//   2 lane0 pc=0x10/0x80, lane1 pc=0x14/0x90 cyc0 -> writes 0x10 cyc1, 0x14 cyc2.
//   3 dual pushes every cycle, DEPTH=4 -> count 2,3 then ret_ready_o=0 at count 3;
//     drains 1/cycle, ready returns at count 2; no entry lost or reordered.
//   4 3 entries queued, flush_req cyc0 -> no writes after cyc0, inv idx 0..255
//     cyc1..256, flush_done cyc257, busy cyc1..257, q_count=0, ready=1 cyc258.
//   5 reset_n low async at inv idx 0x40 -> all outputs 0 immediately, ready=1,
//     flush_done never pulses; new update after release written normally.
//   6 with ATB_UPD_COALESCE_EN: lane0/lane1 both pc=0x200 tgt 0xA0/0xB0 -> one write
//     tgt=0xB0; without macro -> two writes 0xA0 then 0xB0.

Source files
------------

// File: rtl/atb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : atb_pkg                                                    |
// | Description : Shared types for the ATB update/maintenance controller.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package atb_pkg;

   // One retire update destined for the ATB write port
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] tgt_pc;
   } atb_upd_t;

   // Controller sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } atb_ctrl_state_e;

endpackage : atb_pkg
`default_nettype wire

// File: rtl/atb_upd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : atb_upd_fifo                                               |
// | Description : Ordered 2-push / 1-pop update queue with synchronous clear.|
// |               Lane 0 is enqueued ahead of lane 1. With the macro         |
// |               ATB_UPD_COALESCE_EN defined, an update whose pc matches a  |
// |               queued entry that is not popping this cycle rewrites that  |
// |               entry's target instead of taking a new slot.               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module atb_upd_fifo
   import atb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         clear_i,
   input  logic                         push0_i,
   input  atb_upd_t                     upd0_i,
   input  logic                         push1_i,
   input  atb_upd_t                     upd1_i,
   input  logic                         pop_i,
   output atb_upd_t                     head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   atb_upd_t         mem_q [DEPTH];
   atb_upd_t         mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       n_push;

`ifdef ATB_UPD_COALESCE_EN
   logic [DEPTH-1:0] live;
   logic             hit0, hit1;
   logic [PTR_W-1:0] hidx0, hidx1;

   // Locate queued entries (not leaving this cycle) whose pc matches each lane
   always_comb begin
      live  = '0;
      hit0  = 1'b0;
      hit1  = 1'b0;
      hidx0 = '0;
      hidx1 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PTR_W-1:0] off;
         off     = PTR_W'(i) - rd_ptr_q;
         live[i] = (CNT_W'(off) < count_q) && !(pop_i && (PTR_W'(i) == rd_ptr_q));
         if (live[i] && !hit0 && (mem_q[i].pc == upd0_i.pc)) begin
            hit0  = 1'b1;
            hidx0 = PTR_W'(i);
         end
         if (live[i] && !hit1 && (mem_q[i].pc == upd1_i.pc)) begin
            hit1  = 1'b1;
            hidx1 = PTR_W'(i);
         end
      end
   end
`endif

   // Queue next-state: clear dominates, otherwise pop and push(es) net together
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      n_push   = 2'd0;
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
`ifdef ATB_UPD_COALESCE_EN
         if (push0_i) begin
            if (hit0) begin
               mem_d[hidx0].tgt_pc = upd0_i.tgt_pc;
            end else begin
               mem_d[wr_ptr_q] = upd0_i;
               n_push          = n_push + 2'd1;
            end
         end
         if (push1_i) begin
            if (hit1) begin
               mem_d[hidx1].tgt_pc = upd1_i.tgt_pc;
            end else if (push0_i && !hit0 && (upd0_i.pc == upd1_i.pc)) begin
               // Same-pc pair in one cycle collapses onto lane 0's new slot
               mem_d[wr_ptr_q].tgt_pc = upd1_i.tgt_pc;
            end else begin
               mem_d[wr_ptr_q + PTR_W'(n_push)] = upd1_i;
               n_push                          = n_push + 2'd1;
            end
         end
`else
         if (push0_i) begin
            mem_d[wr_ptr_q] = upd0_i;
            n_push          = n_push + 2'd1;
         end
         if (push1_i) begin
            mem_d[wr_ptr_q + PTR_W'(n_push)] = upd1_i;
            n_push                          = n_push + 2'd1;
         end
`endif
         wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
         count_d  = count_q + CNT_W'(n_push) - CNT_W'(pop_i);
      end
   end

   // Queue storage and pointers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule : atb_upd_fifo
`default_nettype wire

// File: rtl/atb_update_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : atb_update_ctrl                                            |
// | Description : Serializes up to two retire updates per cycle onto the     |
// |               single ATB write port and sequences a full-table flush by  |
// |               walking every ATB index on the invalidate port.            |
// |               Optional macro ATB_UPD_COALESCE_EN enables same-pc update  |
// |               coalescing inside the queue.                               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module atb_update_ctrl
   import atb_pkg::*;
#(
   parameter int N     = 256,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         ret0_valid_i,
   input  logic [31:0]                  ret0_pc_i,
   input  logic [31:0]                  ret0_tgt_pc_i,
   input  logic                         ret1_valid_i,
   input  logic [31:0]                  ret1_pc_i,
   input  logic [31:0]                  ret1_tgt_pc_i,
   output logic                         ret_ready_o,
   input  logic                         flush_req_i,
   output logic                         flush_busy_o,
   output logic                         flush_done_o,
   output logic                         atb_wr_valid_o,
   output logic [31:0]                  atb_wr_pc_o,
   output logic [31:0]                  atb_wr_tgt_pc_o,
   output logic                         atb_inv_valid_o,
   output logic [$clog2(N)-1:0]         atb_inv_idx_o,
   output logic [$clog2(DEPTH+1)-1:0]   q_count_o
);

   localparam int IDX_W = $clog2(N);
   localparam int CNT_W = $clog2(DEPTH + 1);

   atb_ctrl_state_e  state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic [CNT_W-1:0] q_count;
   atb_upd_t         head;
   atb_upd_t         upd0, upd1;
   logic             flush_go;
   logic             push0, push1, pop;

   assign upd0 = '{pc: ret0_pc_i, tgt_pc: ret0_tgt_pc_i};
   assign upd1 = '{pc: ret1_pc_i, tgt_pc: ret1_tgt_pc_i};

   // Room for two pushes is judged on the registered count; a same-cycle pop
   // is deliberately not credited so ready never depends on the write port.
   assign ret_ready_o = (state_q == IDLE) && (q_count <= CNT_W'(DEPTH - 2));
   assign push0       = ret0_valid_i && ret_ready_o;
   assign push1       = ret1_valid_i && ret_ready_o;
   assign flush_go    = (state_q == IDLE) && flush_req_i;
   // A flush accepted this cycle voids the head as well, so nothing is written
   assign pop         = (state_q == IDLE) && (q_count != '0) && !flush_req_i;

   atb_upd_fifo #(
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (flush_go),
      .push0_i (push0),
      .upd0_i  (upd0),
      .push1_i (push1),
      .upd1_i  (upd1),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (q_count)
   );

   assign atb_wr_valid_o  = pop;
   assign atb_wr_pc_o     = pop ? head.pc     : 32'd0;
   assign atb_wr_tgt_pc_o = pop ? head.tgt_pc : 32'd0;
   assign flush_busy_o    = (state_q != IDLE);
   assign q_count_o       = q_count;

   // Flush sequencing: next state, index walk and invalidate/done strobes
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      atb_inv_valid_o = 1'b0;
      atb_inv_idx_o   = '0;
      flush_done_o    = 1'b0;
      case (state_q)
         IDLE: begin
            if (flush_go) begin
               state_d = FLUSH;
               idx_d   = '0;
            end
         end
         FLUSH: begin
            atb_inv_valid_o = 1'b1;
            atb_inv_idx_o   = idx_q;
            idx_d           = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(N - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            flush_done_o = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and flush index registers; reset aborts any walk in progress
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

endmodule : atb_update_ctrl
`default_nettype wire

// File: tb/tb_atb_update_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_atb_update_ctrl                                         |
// | Description : Self-checking bench for atb_update_ctrl (N=256, DEPTH=4).  |
// |               Honors ATB_UPD_COALESCE_EN when defined.                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_atb_update_ctrl;
   import atb_pkg::*;

   localparam int N     = 256;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ret0_valid_i, ret1_valid_i;
   logic [31:0] ret0_pc_i, ret0_tgt_pc_i, ret1_pc_i, ret1_tgt_pc_i;
   logic        ret_ready_o, flush_req_i, flush_busy_o, flush_done_o;
   logic        atb_wr_valid_o, atb_inv_valid_o;
   logic [31:0] atb_wr_pc_o, atb_wr_tgt_pc_o;
   logic [7:0]  atb_inv_idx_o;
   logic [2:0]  q_count_o;

   always #5 clk = ~clk;

   atb_update_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .ret0_valid_i    (ret0_valid_i),
      .ret0_pc_i       (ret0_pc_i),
      .ret0_tgt_pc_i   (ret0_tgt_pc_i),
      .ret1_valid_i    (ret1_valid_i),
      .ret1_pc_i       (ret1_pc_i),
      .ret1_tgt_pc_i   (ret1_tgt_pc_i),
      .ret_ready_o     (ret_ready_o),
      .flush_req_i     (flush_req_i),
      .flush_busy_o    (flush_busy_o),
      .flush_done_o    (flush_done_o),
      .atb_wr_valid_o  (atb_wr_valid_o),
      .atb_wr_pc_o     (atb_wr_pc_o),
      .atb_wr_tgt_pc_o (atb_wr_tgt_pc_o),
      .atb_inv_valid_o (atb_inv_valid_o),
      .atb_inv_idx_o   (atb_inv_idx_o),
      .q_count_o       (q_count_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [31:0] p0, input logic [31:0] t0,
                        input logic v1, input logic [31:0] p1, input logic [31:0] t1,
                        input logic fl);
      ret0_valid_i = v0; ret0_pc_i = p0; ret0_tgt_pc_i = t0;
      ret1_valid_i = v1; ret1_pc_i = p1; ret1_tgt_pc_i = t1;
      flush_req_i  = fl;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      step();
   endtask

   // ------------------------------------------------------------------
   // Behavioural reference: an ordered list of pending updates plus a
   // flush phase (0 idle, 1 walking, 2 done) and walk position.
   // ------------------------------------------------------------------
   atb_upd_t mq[$];
   int       m_phase;
   int       m_k;

   function automatic void model_push(input logic [31:0] pc, input logic [31:0] tgt);
      atb_upd_t u;
`ifdef ATB_UPD_COALESCE_EN
      foreach (mq[i]) begin
         if (mq[i].pc == pc) begin
            mq[i].tgt_pc = tgt;
            return;
         end
      end
`endif
      u.pc = pc;
      u.tgt_pc = tgt;
      mq.push_back(u);
   endfunction

   // Compare every output against the model for the current cycle, then advance it
   task automatic model_cycle();
      logic e_ready, e_wr;
      e_ready = (m_phase == 0) && ((DEPTH - mq.size()) >= 2);
      e_wr    = (m_phase == 0) && (mq.size() > 0) && !flush_req_i;
      chk("rnd_ready", ret_ready_o, e_ready);
      chk("rnd_wr_valid", atb_wr_valid_o, e_wr);
      if (e_wr) begin
         chk("rnd_wr_pc", atb_wr_pc_o, mq[0].pc);
         chk("rnd_wr_tgt", atb_wr_tgt_pc_o, mq[0].tgt_pc);
      end
      chk("rnd_inv_valid", atb_inv_valid_o, m_phase == 1);
      if (m_phase == 1) chk("rnd_inv_idx", atb_inv_idx_o, m_k);
      chk("rnd_busy", flush_busy_o, m_phase != 0);
      chk("rnd_done", flush_done_o, m_phase == 2);
      chk("rnd_count", q_count_o, mq.size());
      if (m_phase == 0) begin
         if (flush_req_i) begin
            mq.delete();
            m_phase = 1;
            m_k     = 0;
         end else begin
            if (e_wr) void'(mq.pop_front());
            if (ret0_valid_i && e_ready) model_push(ret0_pc_i, ret0_tgt_pc_i);
            if (ret1_valid_i && e_ready) model_push(ret1_pc_i, ret1_tgt_pc_i);
         end
      end else if (m_phase == 1) begin
         if (m_k == N - 1) m_phase = 2;
         m_k = (m_k + 1) % N;
      end else begin
         m_phase = 0;
      end
   endtask

   typedef struct {
      logic        v0;
      logic [31:0] p0, t0;
      logic        v1;
      logic [31:0] p1, t1;
      logic        e_ready;
      logic        e_wr;
      logic [31:0] e_pc, e_tgt;
      int          e_cnt;
   } vec_t;

   vec_t vt[15];

   function automatic vec_t mk(input logic v0, input logic [31:0] p0, input logic [31:0] t0,
                               input logic v1, input logic [31:0] p1, input logic [31:0] t1,
                               input logic er, input logic ew, input logic [31:0] ep,
                               input logic [31:0] et, input int ec);
      vec_t v;
      v.v0 = v0; v.p0 = p0; v.t0 = t0; v.v1 = v1; v.p1 = p1; v.t1 = t1;
      v.e_ready = er; v.e_wr = ew; v.e_pc = ep; v.e_tgt = et; v.e_cnt = ec;
      return v;
   endfunction

   initial begin
      int done_seen;

      // Per-cycle directed vectors: single write, dual-lane order, back-pressure and drain
      vt[0]  = mk(1, 32'h100,  32'h200,  0, 0,        0,        1, 0, 0,        0,        0);
      vt[1]  = mk(0, 0,        0,        0, 0,        0,        1, 1, 32'h100,  32'h200,  1);
      vt[2]  = mk(0, 0,        0,        0, 0,        0,        1, 0, 0,        0,        0);
      vt[3]  = mk(1, 32'h10,   32'h80,   1, 32'h14,   32'h90,   1, 0, 0,        0,        0);
      vt[4]  = mk(0, 0,        0,        0, 0,        0,        1, 1, 32'h10,   32'h80,   2);
      vt[5]  = mk(0, 0,        0,        0, 0,        0,        1, 1, 32'h14,   32'h90,   1);
      vt[6]  = mk(0, 0,        0,        0, 0,        0,        1, 0, 0,        0,        0);
      vt[7]  = mk(1, 32'h1000, 32'h9000, 1, 32'h1004, 32'h9004, 1, 0, 0,        0,        0);
      vt[8]  = mk(1, 32'h1008, 32'h9008, 1, 32'h100C, 32'h900C, 1, 1, 32'h1000, 32'h9000, 2);
      vt[9]  = mk(1, 32'hBAD0, 32'hBAD1, 1, 32'hBAD4, 32'hBAD5, 0, 1, 32'h1004, 32'h9004, 3);
      vt[10] = mk(1, 32'h1010, 32'h9010, 1, 32'h1014, 32'h9014, 1, 1, 32'h1008, 32'h9008, 2);
      vt[11] = mk(1, 32'hBAD8, 32'hBAD9, 1, 32'hBADC, 32'hBADD, 0, 1, 32'h100C, 32'h900C, 3);
      vt[12] = mk(0, 0,        0,        0, 0,        0,        1, 1, 32'h1010, 32'h9010, 2);
      vt[13] = mk(0, 0,        0,        0, 0,        0,        1, 1, 32'h1014, 32'h9014, 1);
      vt[14] = mk(0, 0,        0,        0, 0,        0,        1, 0, 0,        0,        0);

      // Reset state
      do_reset();
      chk("rst_ready", ret_ready_o, 1);
      chk("rst_wr_valid", atb_wr_valid_o, 0);
      chk("rst_inv_valid", atb_inv_valid_o, 0);
      chk("rst_busy", flush_busy_o, 0);
      chk("rst_done", flush_done_o, 0);
      chk("rst_count", q_count_o, 0);

      for (int i = 0; i < 15; i++) begin
         drive(vt[i].v0, vt[i].p0, vt[i].t0, vt[i].v1, vt[i].p1, vt[i].t1, 0);
         #1;
         chk($sformatf("vec%0d_ready", i), ret_ready_o, vt[i].e_ready);
         chk($sformatf("vec%0d_wr_valid", i), atb_wr_valid_o, vt[i].e_wr);
         if (vt[i].e_wr) begin
            chk($sformatf("vec%0d_wr_pc", i), atb_wr_pc_o, vt[i].e_pc);
            chk($sformatf("vec%0d_wr_tgt", i), atb_wr_tgt_pc_o, vt[i].e_tgt);
         end
         chk($sformatf("vec%0d_count", i), q_count_o, vt[i].e_cnt);
         step();
      end

      // Flush with three entries queued: no writes, full index walk, done pulse
      drive(1, 32'h500, 32'h600, 1, 32'h504, 32'h604, 0);
      step();
      drive(1, 32'h508, 32'h608, 1, 32'h50C, 32'h60C, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 1);
      #1;
      chk("fl_c0_count", q_count_o, 3);
      chk("fl_c0_wr_valid", atb_wr_valid_o, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < N; k++) begin
         chk("fl_inv_valid", atb_inv_valid_o, 1);
         chk("fl_inv_idx", atb_inv_idx_o, k);
         chk("fl_busy", flush_busy_o, 1);
         chk("fl_wr_valid", atb_wr_valid_o, 0);
         chk("fl_done_early", flush_done_o, 0);
         flush_req_i = (k == 10);
         step();
      end
      flush_req_i = 1'b0;
      chk("fl_done", flush_done_o, 1);
      chk("fl_done_busy", flush_busy_o, 1);
      chk("fl_done_inv", atb_inv_valid_o, 0);
      step();
      chk("fl_after_busy", flush_busy_o, 0);
      chk("fl_after_done", flush_done_o, 0);
      chk("fl_after_ready", ret_ready_o, 1);
      chk("fl_after_count", q_count_o, 0);
      chk("fl_after_wr", atb_wr_valid_o, 0);

      // Asynchronous reset in the middle of a flush walk
      drive(0, 0, 0, 0, 0, 0, 1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (8'h40) step();
      chk("ar_idx_before", atb_inv_idx_o, 32'h40);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_inv_valid", atb_inv_valid_o, 0);
      chk("ar_inv_idx", atb_inv_idx_o, 0);
      chk("ar_busy", flush_busy_o, 0);
      chk("ar_done", flush_done_o, 0);
      chk("ar_ready", ret_ready_o, 1);
      chk("ar_count", q_count_o, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      done_seen = 0;
      for (int k = 0; k < N + 4; k++) begin
         if (flush_done_o || flush_busy_o) done_seen++;
         step();
      end
      chk("ar_no_done", done_seen, 0);
      drive(1, 32'h300, 32'h400, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("ar_post_wr_valid", atb_wr_valid_o, 1);
      chk("ar_post_wr_pc", atb_wr_pc_o, 32'h300);
      chk("ar_post_wr_tgt", atb_wr_tgt_pc_o, 32'h400);
      step();

      // Same-pc pair on both lanes
      drive(1, 32'h200, 32'hA0, 1, 32'h200, 32'hB0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("dup_w1_valid", atb_wr_valid_o, 1);
`ifdef ATB_UPD_COALESCE_EN
      chk("dup_w1_tgt", atb_wr_tgt_pc_o, 32'hB0);
      step();
      chk("dup_w2_valid", atb_wr_valid_o, 0);
`else
      chk("dup_w1_tgt", atb_wr_tgt_pc_o, 32'hA0);
      step();
      chk("dup_w2_valid", atb_wr_valid_o, 1);
      chk("dup_w2_tgt", atb_wr_tgt_pc_o, 32'hB0);
`endif
      step();
      chk("dup_end_count", q_count_o, 0);

      // Randomized traffic against the reference model
      do_reset();
      mq.delete();
      m_phase = 0;
      m_k     = 0;
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 9) < 7, 32'($urandom_range(0, 4)) << 2, $urandom,
               $urandom_range(0, 9) < 6, 32'($urandom_range(0, 4)) << 2, $urandom,
               $urandom_range(0, 499) == 0);
         #1;
         model_cycle();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_atb_update_ctrl
`default_nettype wire
